// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - SAP-1 sequencer shared types: opcodes, control word layout, ring states
package sap1_pkg;

    localparam int OP_W     = 4;
    localparam int RING_LEN = 6;

    typedef enum logic [OP_W-1:0] {
        LDA = 4'h0,
        ADD = 4'h1,
        SUB = 4'h2,
        OUT = 4'hE,
        HLT = 4'hF
    } opcode_t;

    // Field order matches the CON bus, MSB first.
    typedef struct packed {
        logic cp;
        logic ep;
        logic lm;
        logic ce;
        logic li;
        logic ei;
        logic la;
        logic ea;
        logic su;
        logic eu;
        logic lb;
        logic lo;
    } con_t;

    localparam logic [RING_LEN-1:0] T1 = 6'b000001;
    localparam logic [RING_LEN-1:0] T2 = 6'b000010;
    localparam logic [RING_LEN-1:0] T3 = 6'b000100;
    localparam logic [RING_LEN-1:0] T4 = 6'b001000;
    localparam logic [RING_LEN-1:0] T5 = 6'b010000;
    localparam logic [RING_LEN-1:0] T6 = 6'b100000;

endpackage

// File: rtl/controller_sequencer_if.sv
// rtl/controller_sequencer_if.sv - sequencer/datapath bus: opcode in, control word and ring state out
//   IR_OP : opcode from IR[7:4]
//   CON   : 12-bit control word {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
//   T     : one-hot ring state, zero while halted
//   HLT   : registered halt flag
interface controller_sequencer_if;
    logic [sap1_pkg::OP_W-1:0]     IR_OP;
    logic [11:0]                   CON;
    logic [sap1_pkg::RING_LEN-1:0] T;
    logic                          HLT;

    modport master (input IR_OP, output CON, output T, output HLT);
    modport slave  (output IR_OP, input CON, input T, input HLT);
endinterface

// File: rtl/ring_counter.sv
// rtl/ring_counter.sv - one-hot T1..T6 ring counter with rotate enable
//   CLK : clock
//   CLR : asynchronous active-high reset to T1
//   EN  : rotate when high, hold when low
//   T   : one-hot state
module ring_counter
    import sap1_pkg::*;
(
    input  logic                CLK,
    input  logic                CLR,
    input  logic                EN,
    output logic [RING_LEN-1:0] T
);

    logic [RING_LEN-1:0] r_t;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_t <= T1;
        end else if (EN) begin
            r_t <= {r_t[RING_LEN-2:0], r_t[RING_LEN-1]};
        end
    end

    assign T = r_t;

endmodule

// File: rtl/controller_sequencer.sv
// rtl/controller_sequencer.sv - SAP-1 control unit: ring counter, halt flop and control word decode
//   CLK : clock, rising edge
//   CLR : asynchronous active-high reset
//   bus : master side of controller_sequencer_if (IR_OP in; CON, T, HLT out)
module controller_sequencer
    import sap1_pkg::*;
(
    input  logic CLK,
    input  logic CLR,
    controller_sequencer_if.master bus
);

    logic                r_halt;
    logic                w_halt_next;
    logic [RING_LEN-1:0] w_ring_t;
    con_t                w_con;

    // Halt is taken on the edge that ends T4 of an HLT instruction and then
    // sticks; the ring stops on that same edge.
    assign w_halt_next = r_halt | ((w_ring_t == T4) && (bus.IR_OP == HLT));

    ring_counter u_ring (
        .CLK (CLK),
        .CLR (CLR),
        .EN  (~w_halt_next),
        .T   (w_ring_t)
    );

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_halt <= 1'b0;
        end else begin
            r_halt <= w_halt_next;
        end
    end

    // CON is forced to zero during reset without waiting for a clock.
    always_comb begin
        w_con = '0;
        if (!CLR && !r_halt) begin
            case (w_ring_t)
                T1: begin w_con.ep = 1'b1; w_con.lm = 1'b1; end
                T2: begin w_con.cp = 1'b1; end
                T3: begin w_con.ce = 1'b1; w_con.li = 1'b1; end
                T4: begin
                    case (bus.IR_OP)
                        LDA, ADD, SUB: begin w_con.ei = 1'b1; w_con.lm = 1'b1; end
                        OUT:           begin w_con.ea = 1'b1; w_con.lo = 1'b1; end
                        default:       ;
                    endcase
                end
                T5: begin
                    case (bus.IR_OP)
                        LDA:     begin w_con.ce = 1'b1; w_con.la = 1'b1; end
                        ADD:     begin w_con.ce = 1'b1; w_con.lb = 1'b1; end
                        SUB:     begin w_con.ce = 1'b1; w_con.lb = 1'b1; w_con.su = 1'b1; end
                        default: ;
                    endcase
                end
                T6: begin
                    // Su stays high from T5 so the adder output is settled
                    // before the accumulator loads it.
                    case (bus.IR_OP)
                        ADD:     begin w_con.eu = 1'b1; w_con.la = 1'b1; end
                        SUB:     begin w_con.eu = 1'b1; w_con.la = 1'b1; w_con.su = 1'b1; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.CON = w_con;
    assign bus.T   = r_halt ? '0 : w_ring_t;
    assign bus.HLT = r_halt;

    a_t_onehot: assert property (@(posedge CLK) disable iff (CLR)
        $onehot(bus.T) || ((bus.T == '0) && r_halt));
    a_bus_excl: assert property (@(posedge CLK) disable iff (CLR)
        $onehot0({w_con.ep, w_con.ce, w_con.ei, w_con.ea, w_con.eu}));
    a_lm_la:    assert property (@(posedge CLK) disable iff (CLR)
        !(w_con.lm && w_con.la));

endmodule
